// File: rtl/grf_mp_if.sv
// Register-file port bundle: read/bypass, writeback, issue and status signals.
// Decode/writeback side drives through master; the register file sits on slave.
interface grf_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2,
    parameter int NW = 1
);
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_pending;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic [AW:0]      pend_cnt;
    logic [31:0]      wr_count;

    modport master (
        output rd_addr, we, wa, wd, iss_valid, iss_addr,
        input  rd_data, rd_pending, pend_cnt, wr_count
    );

    modport slave (
        input  rd_addr, we, wa, wd, iss_valid, iss_addr,
        output rd_data, rd_pending, pend_cnt, wr_count
    );
endinterface

// File: rtl/grf_mp.sv
// Multi-port register file with write-to-read bypass and per-register pending scoreboard.
// Reads are combinational (zero latency); writes/issues commit on the edge; never stalls.
module grf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    grf_mp_if.slave  bus
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_ONE = 1;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [AW:0]      pend_cnt_q, pend_cnt_d;
    logic [31:0]      wr_count_q, wr_count_d;
    logic [NW-1:0]    wr_eff;
    logic             iss_eff;
    logic [AW:0]      cnt_inc, cnt_dec;
    logic             dup_addr;

    always_comb begin
        wr_eff = '0;
        for (int j = 0; j < NW; j++) begin
            wr_eff[j] = bus.we[j] && ((ZERO_REG == 0) || (bus.wa[j*AW +: AW] != '0));
        end
        iss_eff = bus.iss_valid && ((ZERO_REG == 0) || (bus.iss_addr != '0));
    end

    // Later write ports override earlier ones, so the highest-index match feeds the bypass.
    always_comb begin
        bus.rd_data    = '0;
        bus.rd_pending = '0;
        for (int k = 0; k < NR; k++) begin
            bus.rd_data[k*DW +: DW] = mem_q[bus.rd_addr[k*AW +: AW]];
            bus.rd_pending[k]       = pend_q[bus.rd_addr[k*AW +: AW]];
            for (int j = 0; j < NW; j++) begin
                if (wr_eff[j] && (bus.wa[j*AW +: AW] == bus.rd_addr[k*AW +: AW])) begin
                    bus.rd_data[k*DW +: DW] = bus.wd[j*DW +: DW];
                    bus.rd_pending[k]       = 1'b0;
                end
            end
            if ((ZERO_REG != 0) && (bus.rd_addr[k*AW +: AW] == '0)) begin
                bus.rd_data[k*DW +: DW] = '0;
            end
        end
    end

    // Issue is applied after the clears so a same-cycle new producer keeps the bit set.
    always_comb begin
        pend_d     = pend_q;
        cnt_inc    = '0;
        cnt_dec    = '0;
        dup_addr   = 1'b0;
        wr_count_d = wr_count_q;
        for (int j = 0; j < NW; j++) begin
            if (wr_eff[j]) begin
                pend_d[bus.wa[j*AW +: AW]] = 1'b0;
                wr_count_d = wr_count_d + 32'd1;
            end
        end
        if (iss_eff) begin
            pend_d[bus.iss_addr] = 1'b1;
            if (!pend_q[bus.iss_addr]) begin
                cnt_inc = CNT_ONE;
            end
        end
        for (int j = 0; j < NW; j++) begin
            dup_addr = 1'b0;
            for (int i = 0; i < j; i++) begin
                if (wr_eff[i] && (bus.wa[i*AW +: AW] == bus.wa[j*AW +: AW])) begin
                    dup_addr = 1'b1;
                end
            end
            if (wr_eff[j] && pend_q[bus.wa[j*AW +: AW]] && !dup_addr &&
                !(iss_eff && (bus.iss_addr == bus.wa[j*AW +: AW]))) begin
                cnt_dec = cnt_dec + CNT_ONE;
            end
        end
        pend_cnt_d = pend_cnt_q + cnt_inc - cnt_dec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
            wr_count_q <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wr_eff[j]) begin
                    mem_q[bus.wa[j*AW +: AW]] <= bus.wd[j*DW +: DW];
                end
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign bus.pend_cnt = pend_cnt_q;
    assign bus.wr_count = wr_count_q;
endmodule

// File: tb/tb_grf_mp.sv
// Bench for grf_mp: directed scenarios plus random traffic, scored against a register/pending model.
module tb_grf_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int ZR    = 1;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grf_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();

    grf_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(ZR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [NR*DW-1:0] rd_data;
        logic [NR-1:0]    rd_pending;
        logic [AW:0]      pend_cnt;
        logic [31:0]      wr_count;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reg [DEPTH];
    bit            m_pend [DEPTH];
    int unsigned   m_wc;
    bit            m_live = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit eff(input int j);
        int a;
        a = int'(bus.wa[j*AW +: AW]);
        return bus.we[j] && !(ZR != 0 && a == 0);
    endfunction

    // Predict this cycle's outputs from the model, then advance the model across the edge.
    task automatic step();
        exp_t e;
        int a;
        int cnt;
        logic [DW-1:0] d;
        bit p;
        e = '0;
        for (int k = 0; k < NR; k++) begin
            a = int'(bus.rd_addr[k*AW +: AW]);
            d = m_reg[a];
            p = m_pend[a];
            for (int j = 0; j < NW; j++) begin
                if (eff(j) && int'(bus.wa[j*AW +: AW]) == a) begin
                    d = bus.wd[j*DW +: DW];
                    p = 1'b0;
                end
            end
            if (ZR != 0 && a == 0) d = '0;
            e.rd_data[k*DW +: DW] = d;
            e.rd_pending[k]       = p;
        end
        cnt = 0;
        for (int r = 0; r < DEPTH; r++) cnt += int'(m_pend[r]);
        e.pend_cnt = cnt[AW:0];
        e.wr_count = m_wc;
        if (m_live) exp_q.push_back(e);

        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_reg[r]  = '0;
                m_pend[r] = 1'b0;
            end
            m_wc   = 0;
            m_live = 1'b1;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (eff(j)) begin
                    m_reg[int'(bus.wa[j*AW +: AW])]  = bus.wd[j*DW +: DW];
                    m_pend[int'(bus.wa[j*AW +: AW])] = 1'b0;
                    m_wc++;
                end
            end
            if (bus.iss_valid && !(ZR != 0 && bus.iss_addr == '0))
                m_pend[int'(bus.iss_addr)] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit rst, input bit [1:0] w, input int a0, input logic [31:0] d0,
                         input int a1, input logic [31:0] d1, input bit iv, input int ia,
                         input int r0, input int r1);
        logic [AW-1:0] t0, t1, ti, q0, q1;
        t0 = a0[AW-1:0]; t1 = a1[AW-1:0]; ti = ia[AW-1:0];
        q0 = r0[AW-1:0]; q1 = r1[AW-1:0];
        reset         = rst;
        bus.we        = w;
        bus.wa        = {t1, t0};
        bus.wd        = {d1, d0};
        bus.iss_valid = iv;
        bus.iss_addr  = ti;
        bus.rd_addr   = {q1, q0};
        step();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < NR; k++) begin
                    chk($sformatf("rd_data%0d", k), 64'(bus.rd_data[k*DW +: DW]), 64'(e.rd_data[k*DW +: DW]));
                    chk($sformatf("rd_pending%0d", k), 64'(bus.rd_pending[k]), 64'(e.rd_pending[k]));
                end
                chk("pend_cnt", 64'(bus.pend_cnt), 64'(e.pend_cnt));
                chk("wr_count", 64'(bus.wr_count), 64'(e.wr_count));
            end
        end
    end

    initial begin : driver
        int ra, rb;
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++) drive(0, 2'b00, 0, 0, 0, 0, 0, 0, a, DEPTH - 1 - a);

        // bypass through a single write port, then the array copy
        drive(0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 5);

        // r0 write and issue are both discarded
        drive(0, 2'b01, 0, 32'h1234, 0, 0, 1, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

        // collision: port 1 wins, counted twice
        drive(0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 7, 7);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 7, 7);

        // scoreboard issue / retire / re-issue
        drive(0, 2'b00, 0, 0, 0, 0, 1, 3, 3, 3);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
        drive(0, 2'b01, 3, 32'h55, 0, 0, 0, 0, 3, 3);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);
        drive(0, 2'b10, 0, 0, 3, 32'h66, 1, 3, 3, 3);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 3);

        // reset while r9 is pending and being written
        drive(0, 2'b01, 9, 32'hAA, 0, 0, 1, 9, 9, 3);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3);
        drive(1, 2'b01, 9, 32'hBB, 0, 0, 0, 0, 9, 3);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 3);

        for (int n = 0; n < 3000; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
            rb = int'($urandom_range(0, 7));
            drive(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), $urandom, rb, $urandom,
                  ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
                  ra, int'($urandom_range(0, 7)));
        end

        bus.we = '0;
        bus.iss_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
